// File: rtl/lcd_pkg.sv
// Shared types, command bytes and init ROM for the HD44780-class character LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_SETUP    = 3'd3,
    ST_PULSE    = 3'd4,
    ST_HOLD     = 3'd5,
    ST_WAIT     = 3'd6,
    ST_WRAP     = 3'd7
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_FUNC_8B1L = 8'h30;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  localparam logic [1:0][7:0] ROW_BASE = {8'h40, 8'h00};

  localparam int INIT_LEN = 4;
  // Entry 0 is issued first; it becomes the 1-line function set on single-row panels.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {LCD_CLEAR, LCD_ENTRY_INC, LCD_DISP_ON, LCD_FUNC_8B2L};

  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int at_least_one(input int v);
    if (v < 1) begin
      return 1;
    end else begin
      return v;
    end
  endfunction

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by power-up wait, enable pulse and execution delay.
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Count down while enabled; a load always takes priority and zero is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  assign done = en && (cnt_r == CNT_ONE);

endmodule

// File: rtl/lcd_char_ctrl.sv
// Write-only 8-bit character LCD controller: power-up init, valid/ready byte stream,
// programmable E pulse / execution delays and automatic line wrap.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int E_PULSE_CYC    = 25,
  parameter int POWERUP_US     = 15000,
  parameter int CMD_DELAY_US   = 40,
  parameter int CLEAR_DELAY_US = 1600,
  parameter int COLS           = 16,
  parameter int ROWS           = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_cmd,
  output logic       init_done,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic [7:0] D
);

  localparam int PWR_CYC   = at_least_one(us_to_cyc(CLK_HZ, POWERUP_US));
  localparam int CMD_CYC   = at_least_one(us_to_cyc(CLK_HZ, CMD_DELAY_US));
  localparam int CLEAR_CYC = at_least_one(us_to_cyc(CLK_HZ, CLEAR_DELAY_US));
  localparam int PULSE_CYC = at_least_one(E_PULSE_CYC);
  localparam int MAX_CYC   = max2(max2(PWR_CYC, CLEAR_CYC), max2(CMD_CYC, PULSE_CYC));
  localparam int CNT_W     = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(PWR_CYC);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_CYC);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);

  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [2:0] IDX_DONE  = 3'(INIT_LEN);
  localparam bit         TWO_ROWS  = (ROWS > 1);

  lcd_state_e       state_r;
  logic             rs_r;
  logic             e_r;
  logic [7:0]       d_r;
  logic             in_ready_r;
  logic             init_done_r;
  logic             row_r;
  logic [5:0]       col_r;
  logic [2:0]       init_idx_r;
  logic             wrap_pend_r;

  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_en_s;
  logic             tmr_done_s;
  logic             slow_cmd_s;
  logic [7:0]       init_byte_s;
  logic [5:0]       ddram_col_s;
  logic             next_row_s;

  lcd_delay_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (PWR_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .done     (tmr_done_s)
  );

  // Clear and home need the long execution delay; everything else uses the short one.
  assign slow_cmd_s = !rs_r && ((d_r == LCD_CLEAR) || (d_r == LCD_HOME));
  assign next_row_s = TWO_ROWS ? ~row_r : 1'b0;

  // Timer control: arm the pulse length in SETUP and the execution delay in HOLD.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = PULSE_LD;
    tmr_en_s   = 1'b0;
    case (state_r)
      ST_PWR_WAIT, ST_PULSE, ST_WAIT: begin
        tmr_en_s = 1'b1;
      end
      ST_SETUP: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = PULSE_LD;
      end
      ST_HOLD: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = slow_cmd_s ? CLEAR_LD : CMD_LD;
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b0;
      end
    endcase
  end

  // Next init byte, with the function-set swapped for single-row panels.
  always_comb begin
    init_byte_s = INIT_ROM[init_idx_r[1:0]];
    if ((init_idx_r == 3'd0) && !TWO_ROWS) begin
      init_byte_s = LCD_FUNC_8B1L;
    end else begin
      init_byte_s = INIT_ROM[init_idx_r[1:0]];
    end
  end

  // Set-DDRAM column, clamped so the cursor never points past the visible row.
  always_comb begin
    ddram_col_s = in_data[5:0];
    if (in_data[5:0] > LAST_COL) begin
      ddram_col_s = LAST_COL;
    end else begin
      ddram_col_s = in_data[5:0];
    end
  end

  // Main sequencer: pin drive, handshake, init progress and cursor tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_PWR_WAIT;
      rs_r        <= 1'b0;
      e_r         <= 1'b0;
      d_r         <= 8'h00;
      in_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
      row_r       <= 1'b0;
      col_r       <= 6'd0;
      init_idx_r  <= 3'd0;
      wrap_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_PWR_WAIT: begin
          if (tmr_done_s) begin
            state_r <= ST_INIT;
          end
        end
        ST_INIT: begin
          rs_r       <= 1'b0;
          d_r        <= init_byte_s;
          init_idx_r <= init_idx_r + 3'd1;
          state_r    <= ST_SETUP;
        end
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            rs_r       <= ~in_is_cmd;
            d_r        <= in_data;
            state_r    <= ST_SETUP;
            if (!in_is_cmd) begin
              if (col_r == LAST_COL) begin
                col_r       <= 6'd0;
                row_r       <= next_row_s;
                wrap_pend_r <= 1'b1;
              end else begin
                col_r <= col_r + 6'd1;
              end
            end else if ((in_data == LCD_CLEAR) || (in_data == LCD_HOME)) begin
              row_r <= 1'b0;
              col_r <= 6'd0;
            end else if (in_data[7]) begin
              row_r <= TWO_ROWS ? in_data[6] : 1'b0;
              col_r <= ddram_col_s;
            end
          end
        end
        ST_SETUP: begin
          e_r     <= 1'b1;
          state_r <= ST_PULSE;
        end
        ST_PULSE: begin
          if (tmr_done_s) begin
            e_r     <= 1'b0;
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_done_s) begin
            if (wrap_pend_r) begin
              state_r <= ST_WRAP;
            end else if (!init_done_r && (init_idx_r != IDX_DONE)) begin
              state_r <= ST_INIT;
            end else begin
              init_done_r <= 1'b1;
              in_ready_r  <= 1'b1;
              state_r     <= ST_IDLE;
            end
          end
        end
        ST_WRAP: begin
          rs_r        <= 1'b0;
          d_r         <= LCD_SET_DDRAM | ROW_BASE[row_r];
          wrap_pend_r <= 1'b0;
          state_r     <= ST_SETUP;
        end
        default: begin
          state_r <= ST_PWR_WAIT;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign init_done = init_done_r;
  assign RS        = rs_r;
  assign RW        = 1'b0;
  assign E         = e_r;
  assign D         = d_r;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: init sequence, character/command timing, wrap and reset.
module tb_lcd_char_ctrl;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_is_cmd = 1'b0;
  logic       in_ready;
  logic       init_done;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] D;

  int         checks    = 0;
  int         failures  = 0;
  int         edge_cnt  = 0;
  int         base_edge = 0;
  int         hs_edge   = 0;
  logic       e_prev    = 1'b0;
  logic [8:0] wq[$];

  lcd_char_ctrl #(
    .CLK_HZ         (1_000_000),
    .E_PULSE_CYC    (2),
    .POWERUP_US     (20),
    .CMD_DELAY_US   (4),
    .CLEAR_DELAY_US (10),
    .COLS           (4),
    .ROWS           (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_cmd (in_is_cmd),
    .init_done (init_done),
    .RS        (RS),
    .RW        (RW),
    .E         (E),
    .D         (D)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; latencies are differences of this count.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Capture {RS,D} whenever E is first seen high.
  always @(negedge clk) begin
    if (E && !e_prev) wq.push_back({RS, D});
    e_prev <= E;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input string tag, input logic rs_exp, input logic [7:0] d_exp);
    logic [8:0] got;
    got = 9'bx;
    if (wq.size() > 0) got = wq.pop_front();
    check(tag, {23'd0, got}, {23'd0, rs_exp, d_exp});
  endtask

  task automatic check_cursor(input string tag, input logic row, input logic [5:0] col);
    check({tag, " row"}, {31'd0, dut.row_r}, {31'd0, row});
    check({tag, " col"}, {26'd0, dut.col_r}, {26'd0, col});
  endtask

  // Holds the request until accepted; returns at the falling edge after handshake edge.
  task automatic send_hs(input string tag, input logic [7:0] data, input logic cmd);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = data;
    in_is_cmd = cmd;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    hs_edge = edge_cnt;
    in_valid = 1'b0;
  endtask

  // Edges from handshake until in_ready is seen high again.
  task automatic wait_ready(output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    lat = edge_cnt - hs_edge;
  endtask

  task automatic send_char(input string tag, input logic [7:0] data, input int exp_lat);
    int lat;
    send_hs(tag, data, 1'b0);
    wait_ready(lat);
    check({tag, " latency"}, lat, exp_lat);
    expect_write({tag, " write"}, 1'b1, data);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] data, input int exp_lat);
    int lat;
    send_hs(tag, data, 1'b1);
    wait_ready(lat);
    check({tag, " latency"}, lat, exp_lat);
    expect_write({tag, " write"}, 1'b0, data);
  endtask

  initial begin
    int guard;
    int lat;

    // Reset values while rst is held low.
    @(negedge clk);
    @(negedge clk);
    check("rst RS", {31'd0, RS}, 32'd0);
    check("rst RW", {31'd0, RW}, 32'd0);
    check("rst E", {31'd0, E}, 32'd0);
    check("rst D", {24'd0, D}, 32'h00);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst init_done", {31'd0, init_done}, 32'd0);
    check_cursor("rst cursor", 1'b0, 6'd0);

    // 20 power-up cycles, INIT, SETUP: E is high after the 22nd edge.
    rst = 1'b1;
    base_edge = edge_cnt;
    guard = 0;
    while (!E && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("first E edge", edge_cnt - base_edge, 32'd22);
    check("first E D", {24'd0, D}, 32'h38);
    check("first E RS", {31'd0, RS}, 32'd0);

    // Each init command takes 9 edges (INIT+SETUP+2 pulse+HOLD+4 wait); clear waits 10.
    guard = 0;
    while (!init_done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("init_done edge", edge_cnt - base_edge, 32'd62);
    check("init in_ready", {31'd0, in_ready}, 32'd1);
    expect_write("init 0", 1'b0, 8'h38);
    expect_write("init 1", 1'b0, 8'h0C);
    expect_write("init 2", 1'b0, 8'h06);
    expect_write("init 3", 1'b0, 8'h01);

    // Character 0x41: pin-level timing through SETUP/PULSE/HOLD.
    send_hs("char A", 8'h41, 1'b0);
    check("char SETUP RS", {31'd0, RS}, 32'd1);
    check("char SETUP D", {24'd0, D}, 32'h41);
    check("char SETUP E", {31'd0, E}, 32'd0);
    check("char SETUP in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("char E T+2", {31'd0, E}, 32'd1);
    @(negedge clk);
    check("char E T+3", {31'd0, E}, 32'd1);
    @(negedge clk);
    check("char HOLD E", {31'd0, E}, 32'd0);
    check("char HOLD D", {24'd0, D}, 32'h41);
    wait_ready(lat);
    // in_ready is visible in cycle T+9, which begins at edge T+8.
    check("char latency", lat, 32'd8);
    expect_write("char write", 1'b1, 8'h41);
    check_cursor("after char", 1'b0, 6'd1);

    // Clear: long delay, cursor home.
    send_cmd("clear", 8'h01, 14);
    check_cursor("after clear", 1'b0, 6'd0);

    // ABCD fills row 0; D triggers an auto 0xC0 before in_ready returns.
    send_char("A", 8'h41, 8);
    send_char("B", 8'h42, 8);
    send_char("C", 8'h43, 8);
    send_char("D", 8'h44, 17);
    expect_write("wrap to row1", 1'b0, 8'hC0);
    check_cursor("after ABCD", 1'b1, 6'd0);
    send_char("E", 8'h45, 8);
    send_char("F", 8'h46, 8);
    send_char("G", 8'h47, 8);
    send_char("H", 8'h48, 17);
    expect_write("wrap to row0", 1'b0, 8'h80);
    check_cursor("after EFGH", 1'b0, 6'd0);

    // Set-DDRAM to row 1 col 2: wrap after two characters.
    send_cmd("ddram C2", 8'hC2, 8);
    check_cursor("after C2", 1'b1, 6'd2);
    send_char("x", 8'h78, 8);
    send_char("y", 8'h79, 17);
    expect_write("wrap after C2", 1'b0, 8'h80);
    check_cursor("after xy", 1'b0, 6'd0);

    // Column beyond the panel is clamped to the last column.
    send_cmd("ddram 8F", 8'h8F, 8);
    check_cursor("after 8F", 1'b0, 6'd3);
    send_char("z", 8'h7A, 17);
    expect_write("wrap after 8F", 1'b0, 8'hC0);
    check_cursor("after z", 1'b1, 6'd0);
    check("idle RW", {31'd0, RW}, 32'd0);

    // Reset during the E pulse drops the pins immediately.
    send_hs("rst char", 8'h51, 1'b0);
    @(negedge clk);
    check("pre-reset E", {31'd0, E}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid rst E", {31'd0, E}, 32'd0);
    check("mid rst D", {24'd0, D}, 32'h00);
    check("mid rst RS", {31'd0, RS}, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    check("mid rst init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    base_edge = edge_cnt;
    wq.delete();
    guard = 0;
    while (!E && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("re-init E edge", edge_cnt - base_edge, 32'd22);
    check("re-init D", {24'd0, D}, 32'h38);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
